nasti_demux: RTL

- Address-decoding router that sits directly downstream of nasti_mux.
- Takes the single merged NASTI master stream and routes each AW/W/AR burst to one of up to 8 slave ports by base/mask match.
- Returns B/R responses to the master.
- Unmapped addresses are answered by an internal DECERR responder, so the master never hangs.

---
 rtl/nasti_demux_if.sv | 90 +++++++++
 rtl/nasti_demux.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nasti_demux_if.sv
// nasti_channel: 8-port NASTI (AXI4) channel bundle.
// Every signal is a packed [7:0] array indexed by port number.
// Modports:
//   master - the side that issues AW/W/AR and accepts B/R.
//   slave  - the side that accepts AW/W/AR and returns B/R.
interface nasti_channel #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1
);
  logic [7:0][ID_WIDTH-1:0]     aw_id;
  logic [7:0][ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0][7:0]              aw_len;
  logic [7:0][2:0]              aw_size;
  logic [7:0][1:0]              aw_burst;
  logic [7:0]                   aw_lock;
  logic [7:0][3:0]              aw_cache;
  logic [7:0][2:0]              aw_prot;
  logic [7:0][3:0]              aw_qos;
  logic [7:0][3:0]              aw_region;
  logic [7:0][USER_WIDTH-1:0]   aw_user;
  logic [7:0]                   aw_valid;
  logic [7:0]                   aw_ready;

  logic [7:0][DATA_WIDTH-1:0]   w_data;
  logic [7:0][DATA_WIDTH/8-1:0] w_strb;
  logic [7:0]                   w_last;
  logic [7:0][USER_WIDTH-1:0]   w_user;
  logic [7:0]                   w_valid;
  logic [7:0]                   w_ready;

  logic [7:0][ID_WIDTH-1:0]     b_id;
  logic [7:0][1:0]              b_resp;
  logic [7:0][USER_WIDTH-1:0]   b_user;
  logic [7:0]                   b_valid;
  logic [7:0]                   b_ready;

  logic [7:0][ID_WIDTH-1:0]     ar_id;
  logic [7:0][ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0][7:0]              ar_len;
  logic [7:0][2:0]              ar_size;
  logic [7:0][1:0]              ar_burst;
  logic [7:0]                   ar_lock;
  logic [7:0][3:0]              ar_cache;
  logic [7:0][2:0]              ar_prot;
  logic [7:0][3:0]              ar_qos;
  logic [7:0][3:0]              ar_region;
  logic [7:0][USER_WIDTH-1:0]   ar_user;
  logic [7:0]                   ar_valid;
  logic [7:0]                   ar_ready;

  logic [7:0][ID_WIDTH-1:0]     r_id;
  logic [7:0][DATA_WIDTH-1:0]   r_data;
  logic [7:0][1:0]              r_resp;
  logic [7:0]                   r_last;
  logic [7:0][USER_WIDTH-1:0]   r_user;
  logic [7:0]                   r_valid;
  logic [7:0]                   r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_demux.sv
// nasti_demux: routes the merged NASTI master stream (port 0 of `master`)
// to one of up to SLAVE_NUM slave ports by base/mask address decode.
// Unmapped addresses are answered by internal DECERR write/read responders.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   master   - upstream bundle (nasti_channel.slave), only port 0 used
//   slave    - downstream bundle (nasti_channel.master), ports 0..SLAVE_NUM-1
module nasti_demux #(
  parameter int unsigned SLAVE_NUM  = 8,
  parameter int unsigned W_MAX      = 2,
  parameter int unsigned R_MAX      = 2,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned LITE_MODE  = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE0 = '0, BASE1 = '0, BASE2 = '0, BASE3 = '0,
  parameter logic [ADDR_WIDTH-1:0] BASE4 = '0, BASE5 = '0, BASE6 = '0, BASE7 = '0,
  parameter logic [ADDR_WIDTH-1:0] MASK0 = '0, MASK1 = '0, MASK2 = '0, MASK3 = '0,
  parameter logic [ADDR_WIDTH-1:0] MASK4 = '0, MASK5 = '0, MASK6 = '0, MASK7 = '0
) (
  input logic          clk,
  input logic          rst,
  nasti_channel.slave  master,
  nasti_channel.master slave
);
  localparam int unsigned WCW = $clog2(W_MAX + 1);
  localparam int unsigned RCW = $clog2(R_MAX + 1);
  localparam logic [WCW-1:0] W_MAX_C = WCW'(W_MAX);
  localparam logic [RCW-1:0] R_MAX_C = RCW'(R_MAX);
  localparam logic [7:0][ADDR_WIDTH-1:0] BASES =
    {BASE7, BASE6, BASE5, BASE4, BASE3, BASE2, BASE1, BASE0};
  localparam logic [7:0][ADDR_WIDTH-1:0] MASKS =
    {MASK7, MASK6, MASK5, MASK4, MASK3, MASK2, MASK1, MASK0};

  // Target encoding: bit 3 set means the internal error responder.
  typedef logic [3:0] tgt_t;
  localparam tgt_t TGT_ERR = 4'd8;

  typedef enum logic [1:0] {EW_IDLE, EW_DATA, EW_RESP} ew_state_e;
  typedef enum logic       {ER_IDLE, ER_DATA}          er_state_e;

  function automatic tgt_t decode(input logic [ADDR_WIDTH-1:0] addr);
    tgt_t t;
    logic found;
    t = TGT_ERR;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && (i < SLAVE_NUM) && ((addr & MASKS[i]) == BASES[i])) begin
        t = tgt_t'(i);
        found = 1'b1;
      end
    end
    return t;
  endfunction

  logic            w_lock_q, w_lock_d;
  tgt_t            w_tgt_q, w_tgt_d;
  logic [WCW-1:0]  w_cnt_q, w_cnt_d;
  tgt_t            r_tgt_q, r_tgt_d;
  logic [RCW-1:0]  r_cnt_q, r_cnt_d;
  ew_state_e       ew_state_q, ew_state_d;
  logic [ID_WIDTH-1:0] ew_id_q, ew_id_d;
  er_state_e       er_state_q, er_state_d;
  logic [ID_WIDTH-1:0] er_id_q, er_id_d;
  logic [7:0]      er_cnt_q, er_cnt_d;

  logic run;
  tgt_t aw_tgt, ar_tgt;
  logic aw_ok, ar_ok, aw_rdy, ar_rdy, w_rdy, b_vld, r_vld, r_lst;
  logic aw_hs, w_last_hs, b_hs, ar_hs, r_hs, r_last_hs;
  logic [2:0] w_idx, r_idx;

  assign run   = !rst;
  assign w_idx = w_tgt_q[2:0];
  assign r_idx = r_tgt_q[2:0];

  // Request payloads are broadcast; only the valids are steered.
  assign slave.aw_id     = {8{master.aw_id[0]}};
  assign slave.aw_addr   = {8{master.aw_addr[0]}};
  assign slave.aw_len    = {8{master.aw_len[0]}};
  assign slave.aw_size   = {8{master.aw_size[0]}};
  assign slave.aw_burst  = {8{master.aw_burst[0]}};
  assign slave.aw_lock   = {8{master.aw_lock[0]}};
  assign slave.aw_cache  = {8{master.aw_cache[0]}};
  assign slave.aw_prot   = {8{master.aw_prot[0]}};
  assign slave.aw_qos    = {8{master.aw_qos[0]}};
  assign slave.aw_region = {8{master.aw_region[0]}};
  assign slave.aw_user   = {8{master.aw_user[0]}};
  assign slave.w_data    = {8{master.w_data[0]}};
  assign slave.w_strb    = {8{master.w_strb[0]}};
  assign slave.w_last    = {8{master.w_last[0]}};
  assign slave.w_user    = {8{master.w_user[0]}};
  assign slave.ar_id     = {8{master.ar_id[0]}};
  assign slave.ar_addr   = {8{master.ar_addr[0]}};
  assign slave.ar_len    = {8{master.ar_len[0]}};
  assign slave.ar_size   = {8{master.ar_size[0]}};
  assign slave.ar_burst  = {8{master.ar_burst[0]}};
  assign slave.ar_lock   = {8{master.ar_lock[0]}};
  assign slave.ar_cache  = {8{master.ar_cache[0]}};
  assign slave.ar_prot   = {8{master.ar_prot[0]}};
  assign slave.ar_qos    = {8{master.ar_qos[0]}};
  assign slave.ar_region = {8{master.ar_region[0]}};
  assign slave.ar_user   = {8{master.ar_user[0]}};

  always_comb begin
    master.aw_ready = '0;
    master.w_ready  = '0;
    master.ar_ready = '0;
    master.b_valid  = '0;
    master.b_id     = '0;
    master.b_resp   = '0;
    master.b_user   = '0;
    master.r_valid  = '0;
    master.r_id     = '0;
    master.r_data   = '0;
    master.r_resp   = '0;
    master.r_last   = '0;
    master.r_user   = '0;
    slave.aw_valid  = '0;
    slave.w_valid   = '0;
    slave.ar_valid  = '0;
    slave.b_ready   = '0;
    slave.r_ready   = '0;
    aw_rdy = 1'b0;
    ar_rdy = 1'b0;
    w_rdy  = 1'b0;
    b_vld  = 1'b0;
    r_vld  = 1'b0;
    r_lst  = 1'b0;

    // AW: same-target rule keeps B ordering without per-ID tracking.
    aw_tgt = decode(master.aw_addr[0]);
    aw_ok  = run && !w_lock_q && (w_cnt_q < W_MAX_C) &&
             ((w_cnt_q == '0) || (aw_tgt == w_tgt_q));
    if (aw_tgt[3]) aw_ok = aw_ok && (w_cnt_q == '0) && (ew_state_q == EW_IDLE);
    if (aw_ok) begin
      if (aw_tgt[3]) aw_rdy = 1'b1;
      else begin
        slave.aw_valid[aw_tgt[2:0]] = master.aw_valid[0];
        aw_rdy = slave.aw_ready[aw_tgt[2:0]];
      end
    end
    master.aw_ready[0] = aw_rdy;
    aw_hs = master.aw_valid[0] && aw_rdy;

    // W: only after the owning AW has been accepted.
    if (run && w_lock_q) begin
      if (w_tgt_q[3]) w_rdy = (ew_state_q == EW_DATA);
      else begin
        slave.w_valid[w_idx] = master.w_valid[0];
        w_rdy = slave.w_ready[w_idx];
      end
    end
    master.w_ready[0] = w_rdy;
    w_last_hs = master.w_valid[0] && w_rdy && ((LITE_MODE != 0) || master.w_last[0]);

    // B: ignore responses when nothing is outstanding.
    if (run && (w_cnt_q != '0)) begin
      if (w_tgt_q[3]) begin
        b_vld = (ew_state_q == EW_RESP);
        master.b_id[0]   = ew_id_q;
        master.b_resp[0] = 2'b11;
      end else begin
        b_vld = slave.b_valid[w_idx];
        master.b_id[0]   = slave.b_id[w_idx];
        master.b_resp[0] = slave.b_resp[w_idx];
        master.b_user[0] = slave.b_user[w_idx];
        slave.b_ready[w_idx] = master.b_ready[0];
      end
    end
    master.b_valid[0] = b_vld;
    b_hs = b_vld && master.b_ready[0];

    // AR
    ar_tgt = decode(master.ar_addr[0]);
    ar_ok  = run && (r_cnt_q < R_MAX_C) && ((r_cnt_q == '0) || (ar_tgt == r_tgt_q));
    if (ar_tgt[3]) ar_ok = ar_ok && (r_cnt_q == '0) && (er_state_q == ER_IDLE);
    if (ar_ok) begin
      if (ar_tgt[3]) ar_rdy = 1'b1;
      else begin
        slave.ar_valid[ar_tgt[2:0]] = master.ar_valid[0];
        ar_rdy = slave.ar_ready[ar_tgt[2:0]];
      end
    end
    master.ar_ready[0] = ar_rdy;
    ar_hs = master.ar_valid[0] && ar_rdy;

    // R
    if (run && (r_cnt_q != '0)) begin
      if (r_tgt_q[3]) begin
        r_vld = (er_state_q == ER_DATA);
        r_lst = (er_cnt_q == '0);
        master.r_id[0]   = er_id_q;
        master.r_resp[0] = 2'b11;
      end else begin
        r_vld = slave.r_valid[r_idx];
        r_lst = slave.r_last[r_idx];
        master.r_id[0]   = slave.r_id[r_idx];
        master.r_data[0] = slave.r_data[r_idx];
        master.r_resp[0] = slave.r_resp[r_idx];
        master.r_user[0] = slave.r_user[r_idx];
        slave.r_ready[r_idx] = master.r_ready[0];
      end
    end
    master.r_valid[0] = r_vld;
    master.r_last[0]  = r_lst;
    r_hs      = r_vld && master.r_ready[0];
    r_last_hs = r_hs && ((LITE_MODE != 0) || r_lst);
  end

  always_comb begin
    w_lock_d = w_lock_q;
    w_tgt_d  = w_tgt_q;
    w_cnt_d  = w_cnt_q;
    r_tgt_d  = r_tgt_q;
    r_cnt_d  = r_cnt_q;
    if (aw_hs) begin
      w_lock_d = 1'b1;
      w_tgt_d  = aw_tgt;
    end
    if (w_last_hs) w_lock_d = 1'b0;
    case ({aw_hs, b_hs})
      2'b10:   w_cnt_d = w_cnt_q + WCW'(1);
      2'b01:   w_cnt_d = w_cnt_q - WCW'(1);
      default: w_cnt_d = w_cnt_q;
    endcase
    if (ar_hs) r_tgt_d = ar_tgt;
    case ({ar_hs, r_last_hs})
      2'b10:   r_cnt_d = r_cnt_q + RCW'(1);
      2'b01:   r_cnt_d = r_cnt_q - RCW'(1);
      default: r_cnt_d = r_cnt_q;
    endcase
  end

  always_comb begin
    ew_state_d = ew_state_q;
    ew_id_d    = ew_id_q;
    unique case (ew_state_q)
      EW_IDLE: if (aw_hs && aw_tgt[3]) begin
        ew_state_d = EW_DATA;
        ew_id_d    = master.aw_id[0];
      end
      EW_DATA: if (w_last_hs) ew_state_d = EW_RESP;
      EW_RESP: if (b_hs) ew_state_d = EW_IDLE;
      default: ew_state_d = EW_IDLE;
    endcase
  end

  always_comb begin
    er_state_d = er_state_q;
    er_id_d    = er_id_q;
    er_cnt_d   = er_cnt_q;
    unique case (er_state_q)
      ER_IDLE: if (ar_hs && ar_tgt[3]) begin
        er_state_d = ER_DATA;
        er_id_d    = master.ar_id[0];
        er_cnt_d   = (LITE_MODE != 0) ? '0 : master.ar_len[0];
      end
      ER_DATA: if (r_hs) begin
        if (er_cnt_q == '0) er_state_d = ER_IDLE;
        else                er_cnt_d   = er_cnt_q - 8'd1;
      end
      default: er_state_d = ER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_lock_q   <= 1'b0;
      w_tgt_q    <= '0;
      w_cnt_q    <= '0;
      r_tgt_q    <= '0;
      r_cnt_q    <= '0;
      ew_state_q <= EW_IDLE;
      ew_id_q    <= '0;
      er_state_q <= ER_IDLE;
      er_id_q    <= '0;
      er_cnt_q   <= '0;
    end else begin
      w_lock_q   <= w_lock_d;
      w_tgt_q    <= w_tgt_d;
      w_cnt_q    <= w_cnt_d;
      r_tgt_q    <= r_tgt_d;
      r_cnt_q    <= r_cnt_d;
      ew_state_q <= ew_state_d;
      ew_id_q    <= ew_id_d;
      er_state_q <= er_state_d;
      er_id_q    <= er_id_d;
      er_cnt_q   <= er_cnt_d;
    end
  end

  // Upstream ports 1..7 are not part of the merged stream.
  logic unused_ports;
  assign unused_ports = ^{master.aw_id[7:1], master.aw_addr[7:1], master.aw_len[7:1],
    master.aw_size[7:1], master.aw_burst[7:1], master.aw_lock[7:1], master.aw_cache[7:1],
    master.aw_prot[7:1], master.aw_qos[7:1], master.aw_region[7:1], master.aw_user[7:1],
    master.aw_valid[7:1], master.w_data[7:1], master.w_strb[7:1], master.w_last[7:1],
    master.w_user[7:1], master.w_valid[7:1], master.ar_id[7:1], master.ar_addr[7:1],
    master.ar_len[7:1], master.ar_size[7:1], master.ar_burst[7:1], master.ar_lock[7:1],
    master.ar_cache[7:1], master.ar_prot[7:1], master.ar_qos[7:1], master.ar_region[7:1],
    master.ar_user[7:1], master.ar_valid[7:1], master.b_ready[7:1], master.r_ready[7:1]};
endmodule
